// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared types, constants and the double-dabble adjust step for the display back end
package seg_scan_driver_pkg;

    localparam int         NUM_DIGITS = 3;
    localparam logic [6:0] SEG_BLANK  = 7'b0;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
    typedef logic [3:0] bcd_digit_t;

    // Add 3 to every BCD nibble that is 5 or more, so the following left shift carries correctly
    function automatic logic [4*NUM_DIGITS-1:0] dabble_adjust(input logic [4*NUM_DIGITS-1:0] b);
        logic [4*NUM_DIGITS-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++)
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: CPU-side load bus and display outputs of the segment scan driver
//   value       8   binary value to display (master -> slave)
//   value_valid 1   load strobe, taken only while busy is low (master -> slave)
//   busy        1   conversion in progress (slave -> master)
//   bcd_out     12  committed BCD {hundreds,tens,ones} (slave -> master)
//   segments    7   active-high segment pattern {g,f,e,d,c,b,a} (slave -> master)
//   anode_sel   4   one-hot active-high digit enable, bit0 = ones (slave -> master)
interface seg_scan_driver_if;
    logic [7:0]  value;
    logic        value_valid;
    logic        busy;
    logic [11:0] bcd_out;
    logic [6:0]  segments;
    logic [3:0]  anode_sel;

    modport master (output value, value_valid, input busy, bcd_out, segments, anode_sel);
    modport slave  (input value, value_valid, output busy, bcd_out, segments, anode_sel);
endinterface

// File: rtl/seg_scan_driver_seven_seg.sv
// seven_seg: BCD digit to active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes go dark
//   digit    in  4  BCD digit
//   segments out 7  segment pattern, bit0 = a
module seven_seg
    import seg_scan_driver_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  segments
);
    always_comb begin
        case (digit)
            4'd0:    segments = 7'h3F;
            4'd1:    segments = 7'h06;
            4'd2:    segments = 7'h5B;
            4'd3:    segments = 7'h4F;
            4'd4:    segments = 7'h66;
            4'd5:    segments = 7'h6D;
            4'd6:    segments = 7'h7D;
            4'd7:    segments = 7'h07;
            4'd8:    segments = 7'h7F;
            4'd9:    segments = 7'h6F;
            default: segments = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: latches an 8-bit value, converts it to 3 BCD digits (1 bit/clk) and scans them onto a shared segment bus
//   clk    in  1   system clock
//   reset  in  1   synchronous reset, active-high
//   bus    slave modport of seg_scan_driver_if (value/value_valid in; busy, bcd_out, segments, anode_sel out)
//   SCAN_DIV      clk cycles per digit slot, must exceed GUARD_CYCLES
//   GUARD_CYCLES  dark cycles at the start of each slot (0 = none)
//   Optional macro LEADING_ZERO_BLANK_EN: blank a zero hundreds digit, and a zero tens digit behind it
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 8192,
    parameter int GUARD_CYCLES = 16
) (
    input logic              clk,
    input logic              reset,
    seg_scan_driver_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 2);

    conv_state_t   state;
    logic [2:0]    bit_cnt;
    logic [7:0]    bin;
    logic [11:0]   bcd;
    logic [11:0]   bcd_next;
    logic [11:0]   disp;
    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [GW-1:0] guard;
    bcd_digit_t    digit;
    logic [6:0]    seg_dec;
    logic          blank;
    logic          wrap;

    // Value bcd_out takes at this edge; lets a commit landing on a slot boundary show in that new slot
    assign bcd_next = (state == COMMIT) ? bcd : bus.bcd_out;
    assign wrap     = presc == PW'(SCAN_DIV - 1);
    assign digit    = idx == 2'd2 ? disp[11:8] : idx == 2'd1 ? disp[7:4] : disp[3:0];

`ifdef LEADING_ZERO_BLANK_EN
    assign blank = (idx == 2'd2 && disp[11:8] == 4'd0) || (idx == 2'd1 && disp[11:4] == 8'd0);
`else
    assign blank = 1'b0;
`endif

    seven_seg u_seven_seg (.digit(digit), .segments(seg_dec));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bin         <= '0;
            bcd         <= '0;
            bus.busy    <= 1'b0;
            bus.bcd_out <= '0;
        end else begin
            bus.bcd_out <= bcd_next;
            case (state)
                IDLE: if (bus.value_valid) begin
                    bin      <= bus.value;
                    bcd      <= '0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                    bus.busy <= 1'b1;
                end
                SHIFT: begin
                    {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
                    bit_cnt    <= bit_cnt + 3'd1;
                    state      <= bit_cnt == 3'd7 ? COMMIT : SHIFT;
                end
                COMMIT: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Digits shown are frozen per slot (disp) so a commit never changes a digit mid-slot
    always_ff @(posedge clk) begin
        if (reset) begin
            presc         <= '0;
            idx           <= 2'd0;
            guard         <= GW'(GUARD_CYCLES);
            disp          <= '0;
            bus.anode_sel <= 4'b0;
            bus.segments  <= SEG_BLANK;
        end else begin
            presc         <= wrap ? '0 : presc + 1'b1;
            idx           <= wrap ? (idx == 2'd2 ? 2'd0 : idx + 2'd1) : idx;
            guard         <= wrap ? GW'(GUARD_CYCLES) : (guard != '0 ? guard - 1'b1 : guard);
            disp          <= wrap ? bcd_next : disp;
            bus.anode_sel <= guard != '0 ? 4'b0 : {1'b0, idx == 2'd2, idx == 2'd1, idx == 2'd0};
            bus.segments  <= (guard != '0 || blank) ? SEG_BLANK : seg_dec;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed self-checking bench for seg_scan_driver (SCAN_DIV=8, GUARD_CYCLES=2)
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_busy;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    seg_scan_driver_if bus();

    seg_scan_driver #(.SCAN_DIV(8), .GUARD_CYCLES(2)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10];
        tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tab[d];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        bus.value = v;
        bus.value_valid = 1'b1;
        tick();
        bus.value_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Land on the first lit cycle of a slot for anode a that starts after the call
    task automatic find_slot(input logic [3:0] a, input logic [6:0] seg, input string tag);
        int t = 0;
        while (bus.anode_sel == 4'b0 && t < 200) begin tick(); t++; end
        do begin
            while (bus.anode_sel != 4'b0 && t < 200) begin tick(); t++; end
            while (bus.anode_sel == 4'b0 && t < 200) begin tick(); t++; end
        end while (bus.anode_sel != a && t < 200);
        check({tag, "_anode"}, bus.anode_sel, a);
        check({tag, "_seg"}, bus.segments, seg);
    endtask

    initial begin
        logic [3:0] ea;
        logic [6:0] es;
        bus.value = 8'd0;
        bus.value_valid = 1'b0;
        repeat (3) tick();
        check("rst_anode", bus.anode_sel, 4'b0);
        check("rst_seg", bus.segments, 7'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_bcd", bus.bcd_out, 12'h000);
        reset = 1'b0;
        tick();
        check("guard1_anode", bus.anode_sel, 4'b0);
        tick();
        check("guard2_anode", bus.anode_sel, 4'b0);
        tick();
        check("first_anode", bus.anode_sel, 4'b0001);
        check("first_seg", bus.segments, seg_of(0));

        load(8'd255);
        check("busy_rise", bus.busy, 1'b1);
        wait_idle(n_busy);
        check("busy_len_255", n_busy, 9);
        check("bcd_255", bus.bcd_out, 12'h255);
        find_slot(4'b0001, seg_of(5), "d255_ones");
        find_slot(4'b0010, seg_of(5), "d255_tens");
        find_slot(4'b0100, seg_of(2), "d255_hund");

        load(8'd200);
        tick();
        tick();
        load(8'd17);
        check("busy_during_17", bus.busy, 1'b1);
        wait_idle(n_busy);
        check("bcd_200", bus.bcd_out, 12'h200);
        tick();
        check("no_queue_busy", bus.busy, 1'b0);

        find_slot(4'b0001, seg_of(0), "d200_ones");
        for (int k = 0; k < 72; k++) begin
            int p;
            p = (k + 2) % 24;
            ea = (p % 8) < 2 ? 4'b0 : 4'(1 << (p / 8));
            es = (p % 8) < 2 ? 7'h00 : (p / 8 == 2 ? seg_of(2) : seg_of(0));
            check($sformatf("scan_%0d", k), {bus.anode_sel, 1'b0, bus.segments}, {ea, 1'b0, es});
            tick();
        end

        load(8'd7);
        wait_idle(n_busy);
        check("bcd_7", bus.bcd_out, 12'h007);
        find_slot(4'b0100, LZB ? 7'h00 : seg_of(0), "d7_hund");
        find_slot(4'b0010, LZB ? 7'h00 : seg_of(0), "d7_tens");
        find_slot(4'b0001, seg_of(7), "d7_ones");

        load(8'd105);
        wait_idle(n_busy);
        check("bcd_105", bus.bcd_out, 12'h105);
        find_slot(4'b0100, seg_of(1), "d105_hund");
        find_slot(4'b0010, seg_of(0), "d105_tens");
        find_slot(4'b0001, seg_of(5), "d105_ones");

        load(8'd99);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_bcd", bus.bcd_out, 12'h000);
        load(8'd42);
        check("reload_busy", bus.busy, 1'b1);
        wait_idle(n_busy);
        check("busy_len_42", n_busy, 9);
        check("bcd_42", bus.bcd_out, 12'h042);
        find_slot(4'b0010, seg_of(4), "d42_tens");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
